traffic_light_ctrl: RTL and testbench

//  Parametrised two-approach intersection controller: main road (NS) and side road (EW).

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/traffic_light_ctrl_tick_gen.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 129 ++++++++++++
 tb/tb_traffic_light_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and the fixed phase ordering for the
// two-approach intersection controller.
package traffic_pkg;

   localparam logic [2:0] NS_GREEN  = 3'd0;
   localparam logic [2:0] NS_YELLOW = 3'd1;
   localparam logic [2:0] ALL_RED_1 = 3'd2;
   localparam logic [2:0] EW_GREEN  = 3'd3;
   localparam logic [2:0] EW_YELLOW = 3'd4;
   localparam logic [2:0] ALL_RED_2 = 3'd5;
   localparam logic [2:0] FLASH     = 3'd6;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   typedef struct packed {
      logic [2:0] ns;
      logic [2:0] ew;
   } lamp_pair_t;

   function automatic logic [2:0] next_in_cycle(input logic [2:0] ph);
      return (ph == ALL_RED_2) ? NS_GREEN : ph + 3'd1;
   endfunction

   // FLASH maps to its "yellows on" half; the blink itself is handled by the caller.
   function automatic lamp_pair_t lamps_for(input logic [2:0] ph);
      lamp_pair_t lp;
      lp.ns = LAMP_RED;
      lp.ew = LAMP_RED;
      case (ph)
         NS_GREEN:  lp.ns = LAMP_GRN;
         NS_YELLOW: lp.ns = LAMP_YEL;
         EW_GREEN:  lp.ew = LAMP_GRN;
         EW_YELLOW: lp.ew = LAMP_YEL;
         FLASH: begin
            lp.ns = LAMP_YEL;
            lp.ew = LAMP_YEL;
         end
         default: ;
      endcase
      return lp;
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks.
module tick_gen #(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   // Combinational so the tick lands in the same cycle the count reaches LAST.
   assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase intersection controller with pedestrian green truncation,
// night flashing-yellow mode and a registered per-phase countdown.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int CLK_DIV     = 50_000_000,
   parameter int CNT_W       = 6,
   parameter int T_GREEN     = 30,
   parameter int T_YELLOW    = 3,
   parameter int T_ALLRED    = 2,
   parameter int T_MIN_GREEN = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ped_req,
   input  logic             night,
   output logic [2:0]       ns_lamp,
   output logic [2:0]       ew_lamp,
   output logic [CNT_W-1:0] time_left,
   output logic [2:0]       phase,
   output logic             tick
);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("traffic_light_ctrl: CLK_DIV must be >= 2");
   end
   if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1) begin : g_bad_duration
      $error("traffic_light_ctrl: phase durations must be >= 1");
   end
   if (T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN) begin : g_bad_min_green
      $error("traffic_light_ctrl: T_MIN_GREEN must be in 1..T_GREEN");
   end
   if (CNT_W < 1 || CNT_W > 30 || T_GREEN >= (1 << CNT_W) || T_YELLOW >= (1 << CNT_W)
       || T_ALLRED >= (1 << CNT_W)) begin : g_bad_cnt_w
      $error("traffic_light_ctrl: durations must fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] TL_GREEN  = CNT_W'(T_GREEN);
   localparam logic [CNT_W-1:0] TL_YELLOW = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] TL_ALLRED = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] TL_MIN    = CNT_W'(T_MIN_GREEN);

   logic             ped_pending;
   logic             next_pending;
   logic             in_green;
   logic             enter_yellow;
   logic [2:0]       next_phase;
   logic [CNT_W-1:0] next_time;
   lamp_pair_t       next_lamps;

   tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   function automatic logic [CNT_W-1:0] duration_of(input logic [2:0] ph);
      case (ph)
         NS_GREEN, EW_GREEN:   return TL_GREEN;
         NS_YELLOW, EW_YELLOW: return TL_YELLOW;
         default:              return TL_ALLRED;
      endcase
   endfunction

   assign in_green     = (phase == NS_GREEN) || (phase == EW_GREEN);
   assign enter_yellow = tick && in_green && !night && (time_left == CNT_W'(1));

   // Night has priority over both the countdown and a pending pedestrian request.
   always_comb begin
      next_phase = phase;
      next_time  = time_left;
      if (phase == FLASH) begin
         if (!night) begin
            next_phase = ALL_RED_2;
            next_time  = TL_ALLRED;
         end
      end else if (night) begin
         next_phase = FLASH;
         next_time  = '0;
      end else if (time_left == CNT_W'(1)) begin
         next_phase = next_in_cycle(phase);
         next_time  = duration_of(next_phase);
      end else if (in_green && ped_pending && (time_left > TL_MIN)) begin
         next_time = TL_MIN;
      end else begin
         next_time = time_left - CNT_W'(1);
      end
   end

   always_comb begin
      next_lamps = lamps_for(next_phase);
      if (phase == FLASH && next_phase == FLASH) begin
         next_lamps.ns = ns_lamp ^ LAMP_YEL;
         next_lamps.ew = ew_lamp ^ LAMP_YEL;
      end
   end

   // A request arriving on the very edge that serves the previous one stays latched.
   always_comb begin
      if (phase == FLASH || (tick && night)) begin
         next_pending = 1'b0;
      end else if (enter_yellow) begin
         next_pending = ped_req;
      end else begin
         next_pending = ped_pending | ped_req;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase       <= ALL_RED_2;
         time_left   <= TL_ALLRED;
         ns_lamp     <= LAMP_RED;
         ew_lamp     <= LAMP_RED;
         ped_pending <= 1'b0;
      end else begin
         ped_pending <= next_pending;
         if (tick) begin
            phase     <= next_phase;
            time_left <= next_time;
            ns_lamp   <= next_lamps.ns;
            ew_lamp   <= next_lamps.ew;
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a tick-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized ped/night/reset traffic.
module tb_traffic_light_ctrl;

   localparam int CLK_DIV     = 4;
   localparam int CNT_W       = 6;
   localparam int T_GREEN     = 5;
   localparam int T_YELLOW    = 2;
   localparam int T_ALLRED    = 1;
   localparam int T_MIN_GREEN = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             ped_req = 1'b0;
   logic             night = 1'b0;
   logic [2:0]       ns_lamp;
   logic [2:0]       ew_lamp;
   logic [CNT_W-1:0] time_left;
   logic [2:0]       phase;
   logic             tick;

   int checks = 0;
   int errors = 0;

   // Model: phase index 0..5 in cycle order, 6 = flashing; time left = length - elapsed.
   int m_phase = 5;
   int m_elapsed = 0;
   int m_len = T_ALLRED;
   int m_cycles = 0;
   bit m_yellow_on = 1'b0;
   bit m_pending = 1'b0;
   bit was_flash;
   int ns_table[6] = '{1, 2, 4, 4, 4, 4};
   int ew_table[6] = '{4, 4, 4, 1, 2, 4};

   traffic_light_ctrl #(
      .CLK_DIV     (CLK_DIV),
      .CNT_W       (CNT_W),
      .T_GREEN     (T_GREEN),
      .T_YELLOW    (T_YELLOW),
      .T_ALLRED    (T_ALLRED),
      .T_MIN_GREEN (T_MIN_GREEN)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ped_req   (ped_req),
      .night     (night),
      .ns_lamp   (ns_lamp),
      .ew_lamp   (ew_lamp),
      .time_left (time_left),
      .phase     (phase),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   function automatic int dur_of(input int p);
      if (p == 0 || p == 3) return T_GREEN;
      if (p == 1 || p == 4) return T_YELLOW;
      return T_ALLRED;
   endfunction

   function automatic int exp_time();
      return (m_phase == 6) ? 0 : m_len - m_elapsed;
   endfunction

   function automatic int exp_ns();
      if (m_phase == 6) return m_yellow_on ? 2 : 0;
      return ns_table[m_phase];
   endfunction

   function automatic int exp_ew();
      if (m_phase == 6) return m_yellow_on ? 2 : 0;
      return ew_table[m_phase];
   endfunction

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase     = 5;
         m_elapsed   = 0;
         m_len       = T_ALLRED;
         m_yellow_on = 1'b0;
         m_pending   = 1'b0;
         m_cycles    = 0;
      end else begin
         was_flash = (m_phase == 6);
         if (m_cycles % CLK_DIV == CLK_DIV - 1) begin
            if (was_flash) begin
               if (night) begin
                  m_yellow_on = !m_yellow_on;
               end else begin
                  m_phase   = 5;
                  m_elapsed = 0;
                  m_len     = T_ALLRED;
               end
               m_pending = 1'b0;
            end else if (night) begin
               m_phase     = 6;
               m_yellow_on = 1'b1;
               m_pending   = 1'b0;
            end else begin
               m_elapsed++;
               if (m_elapsed == m_len) begin
                  m_phase   = (m_phase + 1) % 6;
                  m_elapsed = 0;
                  m_len     = dur_of(m_phase);
                  if (m_phase == 1 || m_phase == 4) m_pending = 1'b0;
               end else if ((m_phase == 0 || m_phase == 3) && m_pending
                            && (m_len - m_elapsed + 1) > T_MIN_GREEN) begin
                  m_len = m_elapsed + T_MIN_GREEN;
               end
            end
         end
         if (ped_req && !was_flash && m_phase != 6) m_pending = 1'b1;
         m_cycles++;
      end
   end

   always @(negedge clk) begin
      check_output("model_tick", 32'(tick), 32'(reset && (m_cycles % CLK_DIV == CLK_DIV - 1)));
      check_output("model_phase", 32'(phase), m_phase);
      check_output("model_time_left", 32'(time_left), exp_time());
      check_output("model_ns_lamp", 32'(ns_lamp), exp_ns());
      check_output("model_ew_lamp", 32'(ew_lamp), exp_ew());
   end

   task automatic wait_ticks(input int n);
      repeat (n * CLK_DIV) @(negedge clk);
   endtask

   // Consumes exactly one tick period so the caller stays tick-aligned.
   task automatic pulse_ped();
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      repeat (CLK_DIV - 1) @(negedge clk);
   endtask

   task automatic expect_state(input string name, input int ph, input int tl);
      check_output({name, "_phase"}, 32'(phase), ph);
      check_output({name, "_time"}, 32'(time_left), tl);
   endtask

   task automatic apply_stimulus(input int n_cycles);
      for (int i = 0; i < n_cycles; i++) begin
         @(negedge clk);
         ped_req = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 99) < 2) night = ~night;
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      expect_state("reset", 5, 1);
      check_output("reset_ns", 32'(ns_lamp), 3'b100);
      check_output("reset_ew", 32'(ew_lamp), 3'b100);
      check_output("reset_tick", 32'(tick), 0);
      repeat (CLK_DIV - 1) @(negedge clk);
      check_output("first_tick", 32'(tick), 1);
      @(negedge clk);
      expect_state("ns_green_entry", 0, 5);
      check_output("ns_green_ns", 32'(ns_lamp), 3'b001);
      check_output("ns_green_ew", 32'(ew_lamp), 3'b100);

      // Request at time_left=5 truncates to T_MIN_GREEN, then serves and clears.
      pulse_ped();
      expect_state("ped_trunc", 0, 2);
      wait_ticks(1); expect_state("ped_trunc_1", 0, 1);
      wait_ticks(1); expect_state("ns_yellow", 1, 2);
      check_output("ns_yellow_ns", 32'(ns_lamp), 3'b010);
      wait_ticks(1); expect_state("ns_yellow_1", 1, 1);
      wait_ticks(1); expect_state("all_red_1", 2, 1);
      wait_ticks(1); expect_state("ew_green", 3, 5);
      check_output("ew_green_ew", 32'(ew_lamp), 3'b001);
      wait_ticks(1); expect_state("ew_no_trunc", 3, 4);

      // Request at time_left=2 cannot truncate; one in yellow waits for the next green.
      wait_ticks(2); expect_state("ew_green_2", 3, 2);
      pulse_ped();   expect_state("ped_at_min", 3, 1);
      wait_ticks(1); expect_state("ew_yellow", 4, 2);
      pulse_ped();   expect_state("ped_in_yellow", 4, 1);
      wait_ticks(1); expect_state("all_red_2", 5, 1);
      wait_ticks(1); expect_state("ns_green_held", 0, 5);
      wait_ticks(1); expect_state("held_trunc", 0, 2);
      wait_ticks(2); expect_state("ns_yellow_b", 1, 2);

      // Night mode from EW_GREEN, blink, then resume through ALL_RED_2.
      wait_ticks(3); expect_state("ew_green_b", 3, 5);
      night = 1'b1;
      wait_ticks(1); expect_state("flash", 6, 0);
      check_output("flash_ns_on", 32'(ns_lamp), 3'b010);
      check_output("flash_ew_on", 32'(ew_lamp), 3'b010);
      wait_ticks(1);
      check_output("flash_ns_off", 32'(ns_lamp), 3'b000);
      check_output("flash_ew_off", 32'(ew_lamp), 3'b000);
      wait_ticks(1);
      check_output("flash_ns_on2", 32'(ns_lamp), 3'b010);
      night = 1'b0;
      wait_ticks(1); expect_state("flash_exit", 5, 1);
      check_output("flash_exit_ns", 32'(ns_lamp), 3'b100);
      wait_ticks(1); expect_state("resume", 0, 5);

      // Asynchronous reset between edges, then prescaler restarts from zero.
      wait_ticks(5); expect_state("pre_reset", 1, 2);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      expect_state("async_reset", 5, 1);
      check_output("async_reset_ns", 32'(ns_lamp), 3'b100);
      check_output("async_reset_ew", 32'(ew_lamp), 3'b100);
      check_output("async_reset_tick", 32'(tick), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (CLK_DIV - 2) @(negedge clk);
      check_output("post_reset_no_tick", 32'(tick), 0);
      @(negedge clk);
      check_output("post_reset_tick", 32'(tick), 1);

      apply_stimulus(6000);
      ped_req = 1'b0;
      night   = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
